// File: rtl/display_pkg.sv
// Shared types and constants for the display scanner: scan FSM states,
// anode polarity and BCD digit width.
package display_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      SHOW  = 2'd2
   } scan_state_t;

   localparam int   DIGIT_W = 4;
   localparam logic AN_OFF  = 1'b1;

endpackage

// File: rtl/display_scanner_if.sv
// Bus between the timekeeping logic, the display scanner and the segment decoder.
// master drives the frame and enable; slave (the scanner) drives the display side.
interface display_scanner_if #(
   parameter int NUM_DIGITS = 8
);

   logic                                     en;
   logic [display_pkg::DIGIT_W*NUM_DIGITS-1:0] digits_in;
   logic [NUM_DIGITS-1:0]                    dp_in;
   logic [display_pkg::DIGIT_W-1:0]          digit_out;
   logic                                     dp_out;
   logic [NUM_DIGITS-1:0]                    an;
   logic                                     frame_start;

   modport master (
      output en, digits_in, dp_in,
      input  digit_out, dp_out, an, frame_start
   );

   modport slave (
      input  en, digits_in, dp_in,
      output digit_out, dp_out, an, frame_start
   );

endinterface

// File: rtl/display_scanner_slot_timer.sv
// Per-digit slot prescaler: counts REFRESH_DIV cycles per slot and flags the
// end of the blanking window and the end of the slot.
module slot_timer #(
   parameter int REFRESH_DIV  = 100000,
   parameter int BLANK_CYCLES = 1000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   output logic blank_done_o,
   output logic slot_end_o
);

   localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = (BLANK_CYCLES > 0) ? CNT_W'(BLANK_CYCLES - 1) : '0;

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // slot counter register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // terminal-count compare; the counter never relies on natural wrap
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (cnt_q == SLOT_LAST) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   assign slot_end_o   = (cnt_q == SLOT_LAST);
   assign blank_done_o = (BLANK_CYCLES > 0) && (cnt_q == BLANK_LAST);

endmodule

// File: rtl/display_scanner.sv
// Time-multiplexed BCD digit scanner feeding a 7-segment decoder, with a
// per-slot blanking window and a once-per-scan frame snapshot.
// Optional leading-zero suppression: define DISPLAY_SCANNER_LZ_BLANK_EN.
module display_scanner
   import display_pkg::*;
#(
   parameter int NUM_DIGITS   = 8,
   parameter int REFRESH_DIV  = 100000,
   parameter int BLANK_CYCLES = 1000
) (
   input logic                clk,
   input logic                rst,
   display_scanner_if.slave   bus
);

   localparam int IDX_W = $clog2(NUM_DIGITS);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
   localparam scan_state_t      SLOT_START = (BLANK_CYCLES == 0) ? SHOW : BLANK;

   scan_state_t                      state_q, state_d;
   logic [IDX_W-1:0]                 idx_q, idx_d;
   logic [DIGIT_W*NUM_DIGITS-1:0]    snap_dig_q, snap_dig_d;
   logic [NUM_DIGITS-1:0]            snap_dp_q, snap_dp_d;
   logic [NUM_DIGITS-1:0]            an_q, an_d;
   logic [DIGIT_W-1:0]               digit_q, digit_d;
   logic                             dp_q, dp_d;
   logic                             fs_q, fs_d;
   logic                             take_snap_s;
   logic                             clr_s;
   logic                             blank_done_s;
   logic                             slot_end_s;
   logic [NUM_DIGITS-1:0]            supp_s;

   slot_timer #(
      .REFRESH_DIV  (REFRESH_DIV),
      .BLANK_CYCLES (BLANK_CYCLES)
   ) u_slot_timer (
      .clk          (clk),
      .rst          (rst),
      .clr_i        (clr_s),
      .blank_done_o (blank_done_s),
      .slot_end_o   (slot_end_s)
   );

`ifdef DISPLAY_SCANNER_LZ_BLANK_EN
   logic [NUM_DIGITS-1:0] supp_q, supp_d;

   // a digit is suppressed only while every more significant digit is suppressed too
   function automatic logic [NUM_DIGITS-1:0] lz_mask(
      input logic [DIGIT_W*NUM_DIGITS-1:0] dig,
      input logic [NUM_DIGITS-1:0]         dp
   );
      logic run_s;
      lz_mask = '0;
      run_s   = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         run_s      = run_s && (dig[DIGIT_W*i +: DIGIT_W] == 4'd0) && !dp[i];
         lz_mask[i] = run_s;
      end
   endfunction

   // suppression mask is captured together with the snapshot
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         supp_q <= '0;
      end else begin
         supp_q <= supp_d;
      end
   end

   assign supp_d = take_snap_s ? lz_mask(bus.digits_in, bus.dp_in) : supp_q;
   assign supp_s = supp_q;
`else
   assign supp_s = '0;
`endif

   // state, index, snapshot and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         snap_dig_q <= '0;
         snap_dp_q  <= '0;
         an_q       <= {NUM_DIGITS{AN_OFF}};
         digit_q    <= 4'd0;
         dp_q       <= 1'b0;
         fs_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         snap_dig_q <= snap_dig_d;
         snap_dp_q  <= snap_dp_d;
         an_q       <= an_d;
         digit_q    <= digit_d;
         dp_q       <= dp_d;
         fs_q       <= fs_d;
      end
   end

   // next-state logic; dropping en overrides everything and parks in IDLE
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      take_snap_s = 1'b0;
      clr_s       = 1'b0;
      if (!bus.en) begin
         state_d = IDLE;
         idx_d   = '0;
         clr_s   = 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               state_d     = SLOT_START;
               idx_d       = '0;
               take_snap_s = 1'b1;
               clr_s       = 1'b1;
            end
            BLANK: begin
               if (blank_done_s) begin
                  state_d = SHOW;
               end else begin
                  state_d = BLANK;
               end
            end
            SHOW: begin
               if (slot_end_s) begin
                  state_d = SLOT_START;
                  if (idx_q == IDX_LAST) begin
                     idx_d       = '0;
                     take_snap_s = 1'b1;
                  end else begin
                     idx_d = idx_q + IDX_W'(1);
                  end
               end else begin
                  state_d = SHOW;
               end
            end
            default: begin
               state_d = IDLE;
               idx_d   = '0;
               clr_s   = 1'b1;
            end
         endcase
      end
   end

   // snapshot and output decode; digit/dp stay valid through blank and show
   always_comb begin
      snap_dig_d = snap_dig_q;
      snap_dp_d  = snap_dp_q;
      if (take_snap_s) begin
         snap_dig_d = bus.digits_in;
         snap_dp_d  = bus.dp_in;
      end else begin
         snap_dig_d = snap_dig_q;
         snap_dp_d  = snap_dp_q;
      end
      an_d = {NUM_DIGITS{AN_OFF}};
      if (bus.en && (state_q == SHOW) && !supp_s[idx_q]) begin
         an_d[idx_q] = ~AN_OFF;
      end else begin
         an_d = {NUM_DIGITS{AN_OFF}};
      end
      digit_d = snap_dig_q[idx_q*DIGIT_W +: DIGIT_W];
      dp_d    = snap_dp_q[idx_q];
      fs_d    = take_snap_s;
   end

   assign bus.an          = an_q;
   assign bus.digit_out   = digit_q;
   assign bus.dp_out      = dp_q;
   assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_display_scanner.sv
// Directed self-checking bench for display_scanner (4 digits, 8-cycle slots,
// 2 blank cycles). Leading-zero expectations follow DISPLAY_SCANNER_LZ_BLANK_EN.
module tb_display_scanner;

   localparam int ND = 4;
   localparam int RD = 8;
   localparam int BC = 2;
`ifdef DISPLAY_SCANNER_LZ_BLANK_EN
   localparam bit LZ = 1'b1;
`else
   localparam bit LZ = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   logic found;

   display_scanner_if #(.NUM_DIGITS(ND)) bus ();

   display_scanner #(
      .NUM_DIGITS   (ND),
      .REFRESH_DIV  (RD),
      .BLANK_CYCLES (BC)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Raise en from IDLE and follow the scan for ncyc cycles after the start edge.
   // Output at sample k reflects the state after edge k-1: slot (k-1)/8, phase (k-1)%8,
   // frame (k-1)/32; anode lit for phase >= 2; frame_start at k = 0 and every 32.
   task automatic run_scan(input string tag, input logic [15:0] val0, input logic [15:0] val1,
                           input logic [3:0] dpv, input logic [3:0] supp0, input logic [3:0] supp1,
                           input int change_at, input int ncyc);
      int          f, s, p;
      logic [15:0] v;
      logic [3:0]  sp, ean;
      bus.digits_in = val0;
      bus.dp_in     = dpv;
      bus.en        = 1'b1;
      for (int k = 0; k <= ncyc; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (k == 0) begin
            check({tag, "_an_start"}, {28'd0, bus.an}, 32'h0000000F);
            check({tag, "_fs_start"}, {31'd0, bus.frame_start}, 32'd1);
         end else begin
            f   = (k - 1) / 32;
            s   = ((k - 1) / 8) % 4;
            p   = (k - 1) % 8;
            v   = (f == 0) ? val0 : val1;
            sp  = (f == 0) ? supp0 : supp1;
            ean = 4'hF;
            if (p >= BC && !sp[s]) begin
               ean[s] = 1'b0;
            end
            check({tag, "_an"},    {28'd0, bus.an},        {28'd0, ean});
            check({tag, "_digit"}, {28'd0, bus.digit_out}, {28'd0, v[s*4 +: 4]});
            check({tag, "_dp"},    {31'd0, bus.dp_out},    {31'd0, dpv[s]});
            check({tag, "_fs"},    {31'd0, bus.frame_start}, {31'd0, (k % 32) == 0});
         end
         check({tag, "_onehot"}, {31'd0, $countones(~bus.an) <= 1}, 32'd1);
         if (k == change_at) begin
            bus.digits_in = val1;
         end
      end
   endtask

   initial begin
      rst           = 1'b1;
      bus.en        = 1'b0;
      bus.digits_in = 16'h0000;
      bus.dp_in     = 4'b0000;
      repeat (3) @(negedge clk);
      check("rst_an",    {28'd0, bus.an},          32'h0000000F);
      check("rst_digit", {28'd0, bus.digit_out},   32'd0);
      check("rst_dp",    {31'd0, bus.dp_out},      32'd0);
      check("rst_fs",    {31'd0, bus.frame_start}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_an", {28'd0, bus.an}, 32'h0000000F);

      // basic scan with a mid-frame input change that must wait for the wrap
      run_scan("scan", 16'h1234, 16'h5678, 4'b0000, 4'b0000, 4'b0000, 12, 64);

      // drop en while digit 2 is shown
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         if (bus.an == 4'b1011) found = 1'b1;
      end
      check("drop_found", {31'd0, found}, 32'd1);
      bus.en = 1'b0;
      @(negedge clk);
      check("drop_an", {28'd0, bus.an}, 32'h0000000F);
      @(negedge clk);
      check("drop_an_hold", {28'd0, bus.an},          32'h0000000F);
      check("drop_fs",      {31'd0, bus.frame_start}, 32'd0);

      // restart from digit 0 with blank phase and a fresh frame_start
      run_scan("restart", 16'h5678, 16'h5678, 4'b0000, 4'b0000, 4'b0000, -1, 8);

      // asynchronous reset mid-show, checked before the next rising edge
      check("pre_rst_an", {28'd0, bus.an}, 32'h0000000E);
      #2 rst = 1'b1;
      #1;
      check("async_an",    {28'd0, bus.an},        32'h0000000F);
      check("async_digit", {28'd0, bus.digit_out}, 32'd0);
      check("async_dp",    {31'd0, bus.dp_out},    32'd0);
      bus.en = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_an", {28'd0, bus.an}, 32'h0000000F);

      // decimal point on digit 2 and a non-BCD code passed through
      run_scan("dp", 16'h0A09, 16'h0A09, 4'b0100,
               LZ ? 4'b1000 : 4'b0000, LZ ? 4'b1000 : 4'b0000, -1, 32);
      bus.en = 1'b0;
      @(negedge clk);
      @(negedge clk);

      // leading zeros: 0050 then all zeros (only digit 0 may remain lit)
      run_scan("lz", 16'h0050, 16'h0000, 4'b0000,
               LZ ? 4'b1100 : 4'b0000, LZ ? 4'b1110 : 4'b0000, 12, 64);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
